// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction
// fields, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      RTYPE_EX = 4'd6,
      RTYPE_WB = 4'd7,
      IMM_EX   = 4'd8,
      IMM_WB   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   // Which rule picks the ALU operation in the current state.
   typedef enum logic [1:0] {
      CLS_ADD   = 2'd0,
      CLS_SUB   = 2'd1,
      CLS_RTYPE = 2'd2,
      CLS_IMM   = 2'd3
   } alu_class_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLL = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;
   localparam logic [3:0] ALU_SLT = 4'b1000;
   localparam logic [3:0] ALU_LUI = 4'b1110;

   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps state class, opcode and funct to an ALU operation, and flags whether the
// instruction is one this controller supports.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  alu_class_t  alu_class,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output logic [3:0]  alu_control,
   output logic        valid
);

   logic [3:0] fn_code;
   logic       fn_ok;
   logic [3:0] imm_code;
   logic       op_ok;

   always_comb begin
      fn_code = ALU_ADD;
      fn_ok   = 1'b1;
      case (funct)
         FN_ADD:  fn_code = ALU_ADD;
         FN_SUB:  fn_code = ALU_SUB;
         FN_AND:  fn_code = ALU_AND;
         FN_OR:   fn_code = ALU_OR;
         FN_XOR:  fn_code = ALU_XOR;
         FN_SLT:  fn_code = ALU_SLT;
         FN_SLL:  fn_code = ALU_SLL;
         FN_SRL:  fn_code = ALU_SRL;
         FN_SRA:  fn_code = ALU_SRA;
         default: fn_ok   = 1'b0;
      endcase
   end

   always_comb begin
      imm_code = ALU_ADD;
      op_ok    = 1'b1;
      case (opcode)
         OP_ADDI:  imm_code = ALU_ADD;
         OP_ANDI:  imm_code = ALU_AND;
         OP_ORI:   imm_code = ALU_OR;
         OP_XORI:  imm_code = ALU_XOR;
         OP_LUI:   imm_code = ALU_LUI;
         OP_RTYPE: op_ok    = fn_ok;
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: op_ok = 1'b1;
         default:  op_ok    = 1'b0;
      endcase
   end

   always_comb begin
      case (alu_class)
         CLS_SUB:   alu_control = ALU_SUB;
         CLS_RTYPE: alu_control = fn_code;
         CLS_IMM:   alu_control = imm_code;
         default:   alu_control = ALU_ADD;
      endcase
   end

   assign valid = op_ok;

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle MIPS datapath; stalls on mem_ready
// and resolves BEQ/BNE from the ALU zero flag in the BRANCH state.
module multicycle_controller
   import mips_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        iord,
   output logic        mem_write,
   output logic        mem_read,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_src,
   output logic [3:0]  alu_control,
   output logic        illegal,
   output logic [3:0]  state
);

   state_t     state_q;
   state_t     state_d;
   alu_class_t alu_class;
   logic       op_valid;

   alu_decoder u_alu_decoder (
      .alu_class   (alu_class),
      .opcode      (opcode),
      .funct       (funct),
      .alu_control (alu_control),
      .valid       (op_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            state_d = FETCH;
            if (op_valid) begin
               case (opcode)
                  OP_LW, OP_SW:   state_d = MEMADR;
                  OP_RTYPE:       state_d = RTYPE_EX;
                  OP_BEQ, OP_BNE: state_d = BRANCH;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = IMM_EX;
                  OP_J:           state_d = JUMP;
                  default:        state_d = FETCH;
               endcase
            end
         end
         MEMADR:   state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:    if (mem_ready) state_d = MEMWB;
         MEMWR:    if (mem_ready) state_d = FETCH;
         RTYPE_EX: state_d = RTYPE_WB;
         IMM_EX:   state_d = IMM_WB;
         default:  state_d = FETCH;
      endcase
   end

   // Kept apart from the output block so the decoder result never feeds back into its own select.
   always_comb begin
      case (state_q)
         BRANCH:   alu_class = CLS_SUB;
         RTYPE_EX: alu_class = CLS_RTYPE;
         IMM_EX:   alu_class = CLS_IMM;
         default:  alu_class = CLS_ADD;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_REG;
      pc_src     = PC_SRC_ALU;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRC_B_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            alu_src_b = SRC_B_IMM_SH;
            illegal   = ~op_valid;
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         RTYPE_EX: alu_src_a = 1'b1;
         RTYPE_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         IMM_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         IMM_WB:   reg_write = 1'b1;
         BRANCH: begin
            alu_src_a = 1'b1;
            pc_src    = PC_SRC_ALUOUT;
            pc_write  = zero ^ (opcode == OP_BNE);
         end
         JUMP: begin
            pc_src   = PC_SRC_JUMP;
            pc_write = 1'b1;
         end
         default: ;
      endcase
      // Reset cycle must never commit a PC, IR, register or memory update.
      if (rst) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         mem_read  = 1'b0;
         illegal   = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle schedules built from the
// instruction class, with random stalls, operands and don't-care mem_ready.
module tb_multicycle_controller;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                  S_MEMWR = 5, S_RTYPE_EX = 6, S_RTYPE_WB = 7, S_IMM_EX = 8,
                  S_IMM_WB = 9, S_BRANCH = 10, S_JUMP = 11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, ir_write, iord, mem_write, mem_read, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, illegal;
   logic [1:0] alu_src_b, pc_src;
   logic [3:0] alu_control, state;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         st;
      logic       rdy;
      logic [5:0] en;   // {pc_write, ir_write, mem_read, mem_write, reg_write, illegal}
      logic [11:0] sel; // {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control}
   } cyc_t;

   multicycle_controller dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .ir_write    (ir_write),
      .iord        (iord),
      .mem_write   (mem_write),
      .mem_read    (mem_read),
      .reg_write   (reg_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .pc_src      (pc_src),
      .alu_control (alu_control),
      .illegal     (illegal),
      .state       (state)
   );

   always #5 clk = ~clk;

   function automatic logic rfn_legal(input logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                        6'b101010, 6'b000000, 6'b000010, 6'b000011};
   endfunction

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000) return rfn_legal(fn);
      return op inside {6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000,
                        6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b000010};
   endfunction

   function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
      case (fn)
         6'b100010: return 4'b0001;
         6'b100100: return 4'b0010;
         6'b100101: return 4'b0011;
         6'b100110: return 4'b0100;
         6'b000000: return 4'b0101;
         6'b000010: return 4'b0110;
         6'b000011: return 4'b0111;
         6'b101010: return 4'b1000;
         default:   return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] imm_alu(input logic [5:0] op);
      case (op)
         6'b001100: return 4'b0010;
         6'b001101: return 4'b0011;
         6'b001110: return 4'b0100;
         6'b001111: return 4'b1110;
         default:   return 4'b0000;
      endcase
   endfunction

   // Expected outputs for one cycle spent in state st.
   function automatic cyc_t mk(input int st, input logic rdy, input logic [5:0] op,
                               input logic [5:0] fn, input logic z);
      cyc_t c;
      logic pcw = 0, irw = 0, mr = 0, mw = 0, rw = 0, ill = 0;
      logic io = 0, rd = 0, m2r = 0, sa = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic [3:0] alu = 4'b0000;
      case (st)
         S_FETCH:    begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
         S_DECODE:   begin sb = 2'b11; ill = !is_legal(op, fn); end
         S_MEMADR:   begin sa = 1; sb = 2'b10; end
         S_MEMRD:    begin mr = 1; io = 1; end
         S_MEMWB:    begin rw = 1; m2r = 1; end
         S_MEMWR:    begin mw = 1; io = 1; end
         S_RTYPE_EX: begin sa = 1; alu = rtype_alu(fn); end
         S_RTYPE_WB: begin rw = 1; rd = 1; end
         S_IMM_EX:   begin sa = 1; sb = 2'b10; alu = imm_alu(op); end
         S_IMM_WB:   rw = 1;
         S_BRANCH:   begin sa = 1; alu = 4'b0001; ps = 2'b01; pcw = z ^ (op == 6'b000101); end
         S_JUMP:     begin ps = 2'b10; pcw = 1; end
         default: ;
      endcase
      c.st  = st;
      c.rdy = rdy;
      c.en  = {pcw, irw, mr, mw, rw, ill};
      c.sel = {io, rd, m2r, sa, sb, ps, alu};
      return c;
   endfunction

   // One instruction: fs fetch stalls, ms memory stalls; then check it lands back in FETCH.
   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fs, input int ms);
      cyc_t q[$];
      logic dc;
      for (int i = 0; i < fs; i++) q.push_back(mk(S_FETCH, 1'b0, op, fn, z));
      q.push_back(mk(S_FETCH, 1'b1, op, fn, z));
      dc = 1'($urandom_range(0, 1));
      q.push_back(mk(S_DECODE, dc, op, fn, z));
      if (is_legal(op, fn)) begin
         dc = 1'($urandom_range(0, 1));
         if (op == 6'b100011) begin
            q.push_back(mk(S_MEMADR, dc, op, fn, z));
            for (int i = 0; i < ms; i++) q.push_back(mk(S_MEMRD, 1'b0, op, fn, z));
            q.push_back(mk(S_MEMRD, 1'b1, op, fn, z));
            q.push_back(mk(S_MEMWB, 1'($urandom_range(0, 1)), op, fn, z));
         end else if (op == 6'b101011) begin
            q.push_back(mk(S_MEMADR, dc, op, fn, z));
            for (int i = 0; i < ms; i++) q.push_back(mk(S_MEMWR, 1'b0, op, fn, z));
            q.push_back(mk(S_MEMWR, 1'b1, op, fn, z));
         end else if (op == 6'b000000) begin
            q.push_back(mk(S_RTYPE_EX, dc, op, fn, z));
            q.push_back(mk(S_RTYPE_WB, 1'($urandom_range(0, 1)), op, fn, z));
         end else if (op == 6'b000100 || op == 6'b000101) begin
            q.push_back(mk(S_BRANCH, dc, op, fn, z));
         end else if (op == 6'b000010) begin
            q.push_back(mk(S_JUMP, dc, op, fn, z));
         end else begin
            q.push_back(mk(S_IMM_EX, dc, op, fn, z));
            q.push_back(mk(S_IMM_WB, 1'($urandom_range(0, 1)), op, fn, z));
         end
      end
      foreach (q[i]) begin
         @(negedge clk);
         rst = 1'b0; opcode = op; funct = fn; zero = z; mem_ready = q[i].rdy;
         #1;
         n_checks += 3;
         if (state !== 4'(q[i].st)) begin
            n_fail++;
            $display("FAIL %s cyc%0d state: got %0d want %0d", tag, i, state, q[i].st);
         end
         if ({pc_write, ir_write, mem_read, mem_write, reg_write, illegal} !== q[i].en) begin
            n_fail++;
            $display("FAIL %s cyc%0d enables(pcw,irw,mr,mw,rw,ill): got %b want %b", tag, i,
                     {pc_write, ir_write, mem_read, mem_write, reg_write, illegal}, q[i].en);
         end
         if ({iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control} !== q[i].sel) begin
            n_fail++;
            $display("FAIL %s cyc%0d selects(iord,rd,m2r,sa,sb,ps,alu): got %b want %b", tag, i,
                     {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control}, q[i].sel);
         end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (state !== 4'd0 || {pc_write, ir_write, mem_read, mem_write, reg_write, illegal} !== 6'b001000) begin
         n_fail++;
         $display("FAIL %s return-to-fetch: got state %0d en %b want state 0 en 001000", tag, state,
                  {pc_write, ir_write, mem_read, mem_write, reg_write, illegal});
      end
   endtask

   task automatic reset_dut();
      @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      opcode = 6'b100011; mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); rst = 1'b1; #1;
         n_checks++;
         if ({pc_write, ir_write, mem_read, mem_write, reg_write, illegal} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset enables cyc%0d: got %b want 000000", i,
                     {pc_write, ir_write, mem_read, mem_write, reg_write, illegal});
         end
      end
      @(negedge clk); rst = 1'b0; #1;
      n_checks++;
      if (state !== 4'd0 || pc_write !== 1'b1 || ir_write !== 1'b1) begin
         n_fail++;
         $display("FAIL reset release: got state %0d pcw %b irw %b want 0 1 1", state, pc_write, ir_write);
      end
      reset_dut();
   endtask

   // Reset asserted in the write cycle of LW (MEMWB) or SW (MEMWR).
   task automatic test_mid_reset(input logic [5:0] op, input int wr_state);
      opcode = op; funct = 6'd0; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) @(negedge clk);
      if (wr_state == S_MEMWB) @(negedge clk);
      rst = 1'b1; #1;
      n_checks++;
      if (state !== 4'(wr_state) || reg_write !== 1'b0 || mem_write !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset op=%b: got state %0d rw %b mw %b want %0d 0 0", op, state,
                  reg_write, mem_write, wr_state);
      end
      @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #1;
      n_checks++;
      if (state !== 4'd0) begin
         n_fail++;
         $display("FAIL mid_reset abandon op=%b: got state %0d want 0", op, state);
      end
   endtask

   task automatic test_lw();          run_instr("lw", 6'b100011, 6'($urandom), 1'($urandom), 0, 0); endtask
   task automatic test_sw_stall();    run_instr("sw_stall", 6'b101011, 6'd0, 1'b0, 0, 3); endtask
   task automatic test_rtype_sra();   run_instr("sra", 6'b000000, 6'b000011, 1'b0, 0, 0); endtask

   task automatic test_branch();
      run_instr("beq_z1", 6'b000100, 6'd0, 1'b1, 0, 0);
      run_instr("beq_z0", 6'b000100, 6'd0, 1'b0, 0, 0);
      run_instr("bne_z1", 6'b000101, 6'd0, 1'b1, 0, 0);
      run_instr("bne_z0", 6'b000101, 6'd0, 1'b0, 0, 0);
   endtask

   task automatic test_illegal();
      run_instr("ill_op", 6'b111111, 6'b100000, 1'b0, 0, 0);
      run_instr("ill_fn", 6'b000000, 6'b001000, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[14] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                              6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
                              6'b000010, 6'b111111, 6'b000001, 6'b010000};
      logic [5:0] fns[9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                             6'b101010, 6'b000000, 6'b000010, 6'b000011};
      for (int n = 0; n < 40; n++) begin
         logic [5:0] op, fn;
         op = ops[$urandom_range(0, 13)];
         fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
         run_instr("rand", op, fn, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_branch();
      test_rtype_sra();
      test_illegal();
      test_mid_reset(6'b100011, S_MEMWB);
      test_mid_reset(6'b101011, S_MEMWR);
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle MIPS datapath, in which one ALU and one unified instruction/data memory are shared across the steps of each instruction. Each cycle it drives every datapath mux select, write enable and ALU operation code. It stalls on a memory-ready handshake and resolves BEQ/BNE from the ALU zero flag. It replaces per-instruction combinational decode in the multi-cycle core and sits between the instruction register and the datapath.

## Interface
- No parameters; all encodings are fixed in the shared package.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction-register bits [31:26].
- funct  in  6  instruction-register bits [5:0].
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  instruction-register load enable.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_write  out  1  memory write request, held until mem_ready.
- mem_read  out  1  memory read request, held until mem_ready.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR.
- alu_src_a  out  1  ALU A operand: 0=PC, 1=A.
- alu_src_b  out  2  ALU B operand: 00=B, 01=constant 4, 10=sign-extended imm, 11=imm<<2.
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- alu_control  out  4  ALU operation: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, LUI 1110.
- illegal  out  1  one-cycle pulse in DECODE when the opcode or R-type funct is unsupported.
- state  out  4  current state, for debug.

## Operation
- States, in encoding order 0-11: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, IMM_EX, IMM_WB, BRANCH, JUMP.
- Outputs are Moore, derived from the state. There are two exceptions: pc_write in BRANCH, and enables gated by mem_ready. Every unlisted output is 0.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, ADD, which precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 100011 (LW) or 101011 (SW) -> MEMADR.
    - 000000 (R-type) -> RTYPE_EX.
    - 000100 (BEQ) or 000101 (BNE) -> BRANCH.
    - 001000, 001100, 001101, 001110, 001111 (ADDI, ANDI, ORI, XORI, LUI) -> IMM_EX.
    - 000010 (J) -> JUMP.
    - Any other opcode, or an unsupported R-type funct -> FETCH, with illegal=1.
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH.
- MEMWR: mem_write=1, iord=1. Waits for mem_ready, then -> FETCH.
- RTYPE_EX:
  - alu_src_a=1, alu_src_b=00.
  - alu_control from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 101010 SLT, 000000 SLL, 000010 SRL, 000011 SRA.
  - -> RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- IMM_EX: alu_src_a=1, alu_src_b=10. alu_control is ADD/AND/OR/XOR/LUI for ADDI/ANDI/ORI/XORI/LUI respectively. -> IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, SUB, pc_src=01.
  - pc_write = zero XOR (opcode==BNE).
  - -> FETCH.
- JUMP: pc_src=10, pc_write=1. -> FETCH.
- opcode and funct are sampled combinationally in every state. The instruction register is stable outside FETCH, so no internal latch is needed.

## Timing
- Reset: rst=1 at a rising edge forces state=FETCH. While rst=1, pc_write, ir_write, reg_write, mem_write, mem_read and illegal are forced to 0 combinationally.
- Cycles per instruction with no stalls: LW 5; SW, R-type and I-type 4; BEQ, BNE and J 3.
- Each cycle that mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. No write enable pulses during a stall.
- mem_ready is ignored in every other state.
- rst asserted mid-instruction abandons the instruction. No register or memory write occurs in the reset cycle.

## Structure
- Package mips_ctrl_pkg holds: the state enum (4-bit), opcode and funct localparams, ALU code localparams, and the alu_src_b/pc_src select encodings.
- Sub-module alu_decoder maps (state class, opcode, funct) to alu_control plus a valid flag. The valid flag feeds illegal.
- The FSM is one state register, one next-state block and one output block.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 with mem_ready=1 -> state=0. pc_write and ir_write are 0 during reset, 1 in the first cycle after release.
- LW (opcode 100011) with mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 and mem_to_reg=1 only in cycle 5.
- SW with mem_ready held 0 for 3 cycles in MEMWR -> mem_write=1 for 4 cycles. Returns to FETCH on the cycle after mem_ready=1. Total 7 cycles.
- BEQ vs BNE, each with zero=1 and zero=0 -> pc_write in BRANCH is 1, 0, 0, 1 respectively, with pc_src=01.
- R-type, funct 000011 -> alu_control=0111 in RTYPE_EX, reg_dst=1 in RTYPE_WB.
- Illegal cases: opcode 111111, and R-type funct 001000 -> each gives illegal=1 for one cycle in DECODE, then state returns to FETCH with no reg_write or mem_write.
